// File: rtl/uart_receiver.sv
// UART receive stage: 8N1, LSB first, idle-high, sampled on an oversampling tick.
// Delivers each correctly framed byte with a one-cycle valid pulse and flags bad stop bits.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx_clk_en,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [1:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_busy = (state != S_IDLE);

  // Synchronizer runs every cycle; only the framing logic waits for rx_clk_en.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end
  end

  // Pulses clear on the very next cycle even without a tick, so they stay one sys_clk wide.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_clk_en) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              tick_cnt <= '0;
              state    <= S_START;
            end
          end
          S_START: begin
            if (tick_cnt == HALF_LAST) begin
              if (rx_s) begin
                state <= S_IDLE;
              end else begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= S_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          S_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              shift_q  <= {rx_s, shift_q[7:1]};
              tick_cnt <= '0;
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          S_STOP: begin
            // Return to IDLE mid stop bit so a start bit right after it is caught.
            if (tick_cnt == FULL_LAST) begin
              if (rx_s) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
              tick_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          default: begin
            tick_cnt <= '0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good bytes, back-to-back frames, glitch,
// framing error, mid-frame reset and a gated oversample enable.
module tb_uart_receiver;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       rx_clk_en;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         vtime [0:31];
  logic [7:0] vdata [0:31];
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic       wide_flag = 1'b0;
  logic       both_flag = 1'b0;

  logic        gated = 1'b0;
  int unsigned en_phase = 0;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .rx_clk_en   (rx_clk_en),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (valid_cnt < 32) begin
        vtime[valid_cnt] = cyc;
        vdata[valid_cnt] = rx_data;
      end
      valid_cnt++;
    end
    if (rx_frame_err) err_cnt++;
    if ((rx_valid && prev_valid) || (rx_frame_err && prev_err)) wide_flag = 1'b1;
    if (rx_valid && rx_frame_err) both_flag = 1'b1;
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (gated) begin
      en_phase  = (en_phase + 1) % 4;
      rx_clk_en = (en_phase == 0);
    end else begin
      rx_clk_en = 1'b1;
    end
  endtask

  task automatic idle(input int unsigned n);
    uart_rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int unsigned cpb);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (cpb) step();
    end
    uart_rx = 1'b1;
  endtask

  int vb;
  int eb;
  logic [7:0] b55;

  initial begin
    rst       = 1'b1;
    rx_clk_en = 1'b1;
    uart_rx   = 1'b1;
    repeat (3) step();
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_err", rx_frame_err, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    rst = 1'b0;
    idle(10);

    // Good byte
    vb = valid_cnt; eb = err_cnt;
    send(8'hA5, 1'b1, 16);
    idle(20);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid_cnt", valid_cnt - vb, 1);
    chk("a5_err_cnt", err_cnt - eb, 0);
    chk("a5_busy", rx_busy, 1'b0);

    // Framing error keeps the previous byte
    vb = valid_cnt; eb = err_cnt;
    send(8'h81, 1'b0, 16);
    idle(40);
    chk("ferr_err_cnt", err_cnt - eb, 1);
    chk("ferr_valid_cnt", valid_cnt - vb, 0);
    chk("ferr_data_kept", rx_data, 8'hA5);
    chk("ferr_busy", rx_busy, 1'b0);

    // Back-to-back frames, no idle gap
    vb = valid_cnt; eb = err_cnt;
    send(8'h00, 1'b1, 16);
    send(8'hFF, 1'b1, 16);
    send(8'h3C, 1'b1, 16);
    idle(20);
    chk("b2b_valid_cnt", valid_cnt - vb, 3);
    chk("b2b_err_cnt", err_cnt - eb, 0);
    chk("b2b_data0", vdata[vb], 8'h00);
    chk("b2b_data1", vdata[vb+1], 8'hFF);
    chk("b2b_data2", vdata[vb+2], 8'h3C);
    chk("b2b_gap01", vtime[vb+1] - vtime[vb], 160);
    chk("b2b_gap12", vtime[vb+2] - vtime[vb+1], 160);

    // Glitch shorter than half a bit
    vb = valid_cnt; eb = err_cnt;
    uart_rx = 1'b0;
    repeat (4) step();
    idle(30);
    chk("glitch_valid_cnt", valid_cnt - vb, 0);
    chk("glitch_err_cnt", err_cnt - eb, 0);
    chk("glitch_busy", rx_busy, 1'b0);
    send(8'h5A, 1'b1, 16);
    idle(20);
    chk("post_glitch_data", rx_data, 8'h5A);
    chk("post_glitch_valid_cnt", valid_cnt - vb, 1);

    // Reset during data bit 3 of 0x55
    vb = valid_cnt; eb = err_cnt;
    b55 = 8'h55;
    uart_rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 3; i++) begin
      uart_rx = b55[i];
      repeat (16) step();
    end
    uart_rx = b55[3];
    repeat (8) step();
    chk("midframe_busy", rx_busy, 1'b1);
    rst = 1'b1;
    uart_rx = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_err", rx_frame_err, 1'b0);
    idle(200);
    chk("abort_valid_cnt", valid_cnt - vb, 0);
    chk("abort_err_cnt", err_cnt - eb, 0);
    send(8'h96, 1'b1, 16);
    idle(20);
    chk("post_rst_data", rx_data, 8'h96);
    chk("post_rst_valid_cnt", valid_cnt - vb, 1);

    // Enable one cycle in four, 64 cycles per bit
    gated = 1'b1;
    en_phase = 0;
    idle(8);
    vb = valid_cnt; eb = err_cnt;
    send(8'hC3, 1'b1, 64);
    idle(40);
    chk("gated_data", rx_data, 8'hC3);
    chk("gated_valid_cnt", valid_cnt - vb, 1);
    chk("gated_err_cnt", err_cnt - eb, 0);
    gated = 1'b0;
    idle(4);

    chk("pulse_width_one", wide_flag, 1'b0);
    chk("valid_err_exclusive", both_flag, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
